// File: rtl/bin_to_bcd_seq_if.sv
// Request/result handshake bundle for the sequential binary-to-BCD converter.
// The master side is the producer/consumer pair; the slave side is the converter.
interface bin_to_bcd_seq_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic                  out_sign;
    logic                  out_overflow;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_bcd,
        input  out_sign,
        input  out_overflow
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_bcd,
        output out_sign,
        output out_overflow
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock, with
// optional two's-complement input (sign-magnitude result) and a sticky overflow flag.
module bin_to_bcd_seq #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3,
    parameter bit          SIGNED = 1'b0
) (
    input logic              clk,
    input logic              rst,
    bin_to_bcd_seq_if.slave  bus
);
    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [BcdW-1:0]   bcd_q, bcd_d;
    logic              ovf_q, ovf_d;
    logic              sign_q, sign_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [BcdW-1:0]   res_bcd_q, res_bcd_d;
    logic              res_sign_q, res_sign_d;
    logic              res_ovf_q, res_ovf_d;

    logic [BcdW-1:0]   bcd_adj;
    logic [WIDTH-1:0]  mag;
    logic              neg;
    logic              carry;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Negating -2^(WIDTH-1) wraps to itself, which is the correct unsigned magnitude.
    assign neg = SIGNED && bus.in_data[WIDTH-1];
    assign mag = neg ? ((~bus.in_data) + WIDTH'(1)) : bus.in_data;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        sign_d     = sign_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        res_bcd_d  = res_bcd_q;
        res_sign_d = res_sign_q;
        res_ovf_d  = res_ovf_q;
        carry      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    shreg_d = mag;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    sign_d  = neg;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                {carry, bcd_d, shreg_d} = {bcd_adj, shreg_q, 1'b0};
                ovf_d = ovf_q | carry;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d    = StDone;
                    valid_d    = 1'b1;
                    res_bcd_d  = bcd_d;
                    res_sign_d = sign_q;
                    res_ovf_d  = ovf_d;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            sign_q     <= 1'b0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            res_bcd_q  <= '0;
            res_sign_q <= 1'b0;
            res_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            sign_q     <= sign_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            res_bcd_q  <= res_bcd_d;
            res_sign_q <= res_sign_d;
            res_ovf_q  <= res_ovf_d;
        end
    end

    assign bus.in_ready     = (state_q == StIdle);
    assign bus.out_valid    = valid_q;
    assign bus.out_bcd      = res_bcd_q;
    assign bus.out_sign     = res_sign_q;
    assign bus.out_overflow = res_ovf_q;
endmodule
